// File: rtl/tone_seq_pkg.sv
// Shared types for the tone sequencer: FSM states, per-segment table entry, pan codes.
// Pan field and pan codes exist only when TONE_SEQ_PAN_EN is defined.
package tone_seq_pkg;

  // Storage widths of one table entry; the top casts its port widths onto these.
  localparam int SEG_DUR_W = 21;
  localparam int SEG_HP_W  = 12;
  localparam int SEG_AMP_W = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

`ifdef TONE_SEQ_PAN_EN
  localparam logic [1:0] PAN_BOTH  = 2'b00;
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;
  localparam logic [1:0] PAN_HALF  = 2'b11;
`endif

  typedef struct packed {
    logic [SEG_DUR_W-1:0] dur;
    logic [SEG_HP_W-1:0]  half;
    logic [SEG_AMP_W-1:0] amp;
`ifdef TONE_SEQ_PAN_EN
    logic [1:0]           pan;
`endif
  } seg_cfg_t;

endpackage

// File: rtl/tone_sequencer_osc.sv
// Square-wave oscillator: half-period counter, polarity flop and signed amplitude mapping.
// A half-period of zero holds a DC level of +amp.
module tone_osc #(
  parameter int DATA_W = 16,
  parameter int HP_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HP_W-1:0]   half,
  input  logic [DATA_W-2:0] amp,
  input  logic              step,
  input  logic              restart,
  output logic [DATA_W-1:0] sample
);

  logic [HP_W-1:0]   ph_cnt;
  logic              pos;
  logic [DATA_W-1:0] amp_ext;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      ph_cnt <= '0;
      pos    <= 1'b1;
    end else if (step && (half != '0)) begin
      if (ph_cnt == half - HP_W'(1)) begin
        ph_cnt <= '0;
        pos    <= ~pos;
      end else begin
        ph_cnt <= ph_cnt + HP_W'(1);
      end
    end
  end

  // Magnitude is one bit narrower than the sample, so negation cannot overflow.
  assign amp_ext = {1'b0, amp};
  assign sample  = (pos || (half == '0)) ? amp_ext : (~amp_ext + DATA_W'(1));

endmodule

// File: rtl/tone_sequencer.sv
// Multi-segment stereo tone sequencer: segment table, playback FSM, duration timer, pan stage.
// Optional per-segment panning is enabled with the TONE_SEQ_PAN_EN macro.
//
// state | meaning
// IDLE  | outputs zero, table writable, waiting for start
// PLAY  | one table step per sample_req, table write-protected
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_SEG = 4,
  parameter int DUR_W   = 21,
  parameter int HP_W    = 12,
  localparam int SEG_W  = $clog2(NUM_SEG)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              sample_req,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_addr,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [HP_W-1:0]   cfg_half,
  input  logic [DATA_W-2:0] cfg_amp,
`ifdef TONE_SEQ_PAN_EN
  input  logic [1:0]        cfg_pan,
`endif
  output logic [DATA_W-1:0] LDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              busy,
  output logic              done,
  output logic [SEG_W-1:0]  seg_idx
);

  state_e            state;
  seg_cfg_t          seg_tab [NUM_SEG];
  seg_cfg_t          cur;
  seg_cfg_t          wr_cfg;
  logic [SEG_W-1:0]  seg;
  logic [DUR_W-1:0]  dur_cnt;
  logic [DUR_W-1:0]  cur_dur;
  logic [DUR_W-1:0]  dur_lim;
  logic [HP_W-1:0]   cur_half;
  logic [DATA_W-2:0] cur_amp;
  logic              play;
  logic              step;
  logic              seg_end;
  logic              last_seg;
  logic              osc_restart;
  logic signed [DATA_W-1:0] osc_sample;
  logic signed [DATA_W-1:0] l_next;
  logic signed [DATA_W-1:0] r_next;

  assign cur      = seg_tab[seg];
  assign cur_dur  = DUR_W'(cur.dur);
  assign cur_half = HP_W'(cur.half);
  assign cur_amp  = (DATA_W-1)'(cur.amp);

  // A zero duration plays as a single sample.
  assign dur_lim  = (cur_dur == '0) ? '0 : cur_dur - DUR_W'(1);

  assign play        = (state == PLAY);
  assign step        = play && sample_req && !stop;
  assign seg_end     = step && (dur_cnt == dur_lim);
  assign last_seg    = (seg == SEG_W'(NUM_SEG - 1));
  assign osc_restart = !play || seg_end || stop;

  always_comb begin
    wr_cfg      = '0;
    wr_cfg.dur  = SEG_DUR_W'(cfg_dur);
    wr_cfg.half = SEG_HP_W'(cfg_half);
    wr_cfg.amp  = SEG_AMP_W'(cfg_amp);
`ifdef TONE_SEQ_PAN_EN
    wr_cfg.pan  = cfg_pan;
`endif
  end

  tone_osc #(
    .DATA_W (DATA_W),
    .HP_W   (HP_W)
  ) u_osc (
    .clk     (Clk),
    .reset   (Reset),
    .half    (cur_half),
    .amp     (cur_amp),
    .step    (step),
    .restart (osc_restart),
    .sample  (osc_sample)
  );

`ifdef TONE_SEQ_PAN_EN
  always_comb begin
    l_next = osc_sample;
    r_next = osc_sample;
    case (cur.pan)
      PAN_BOTH:  ;
      PAN_LEFT:  r_next = '0;
      PAN_RIGHT: l_next = '0;
      PAN_HALF: begin
        l_next = osc_sample >>> 1;
        r_next = osc_sample >>> 1;
      end
    endcase
  end
`else
  assign l_next = osc_sample;
  assign r_next = osc_sample;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      seg     <= '0;
      dur_cnt <= '0;
      LDATA   <= '0;
      RDATA   <= '0;
      done    <= 1'b0;
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_tab[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          LDATA <= '0;
          RDATA <= '0;
          if (cfg_we) begin
            seg_tab[cfg_addr] <= wr_cfg;
          end
          if (start && !stop) begin
            state   <= PLAY;
            seg     <= '0;
            dur_cnt <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            state   <= IDLE;
            seg     <= '0;
            dur_cnt <= '0;
            LDATA   <= '0;
            RDATA   <= '0;
          end else if (sample_req) begin
            LDATA <= l_next;
            RDATA <= r_next;
            if (!seg_end) begin
              dur_cnt <= dur_cnt + DUR_W'(1);
            end else begin
              dur_cnt <= '0;
              if (!last_seg) begin
                seg <= seg + SEG_W'(1);
              end else begin
                seg <= '0;
                // One-shot end: the final sample is replaced by silence on the same edge.
                if (!loop) begin
                  state <= IDLE;
                  done  <= 1'b1;
                  LDATA <= '0;
                  RDATA <= '0;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = play;
  assign seg_idx = seg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer; pan cases run when TONE_SEQ_PAN_EN is defined.
module tb_tone_sequencer;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        stop;
  logic        loop;
  logic        sample_req;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [20:0] cfg_dur;
  logic [11:0] cfg_half;
  logic [14:0] cfg_amp;
  logic [1:0]  cfg_pan;
  logic [15:0] LDATA;
  logic [15:0] RDATA;
  logic        busy;
  logic        done;
  logic [1:0]  seg_idx;

  int total = 0;
  int bad   = 0;

  logic [15:0] seq     [8] = '{16'h1000, 16'hF000, 16'h1000, 16'hF000,
                               16'h0200, 16'h0200, 16'h0000, 16'h0000};
  logic [1:0]  seq_seg [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};

  tone_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .sample_req (sample_req),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_dur    (cfg_dur),
    .cfg_half   (cfg_half),
    .cfg_amp    (cfg_amp),
`ifdef TONE_SEQ_PAN_EN
    .cfg_pan    (cfg_pan),
`endif
    .LDATA      (LDATA),
    .RDATA      (RDATA),
    .busy       (busy),
    .done       (done),
    .seg_idx    (seg_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [20:0] d, input logic [11:0] h,
                    input logic [14:0] m, input logic [1:0] p);
    cfg_we = 1'b1; cfg_addr = a; cfg_dur = d; cfg_half = h; cfg_amp = m; cfg_pan = p;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // One sample strobe, checks on the update edge, then one hold cycle.
  task automatic req(input string tag, input logic [15:0] el, input logic [15:0] er,
                     input logic ed, input logic [1:0] es);
    sample_req = 1'b1;
    cyc();
    sample_req = 1'b0;
    chk({tag, "_l"}, 32'(LDATA), 32'(el));
    chk({tag, "_r"}, 32'(RDATA), 32'(er));
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_seg"}, 32'(seg_idx), 32'(es));
    cyc();
    chk({tag, "_hold"}, 32'(LDATA), 32'(el));
  endtask

  task automatic load_base();
    wr(2'd0, 21'd4, 12'd1, 15'h1000, 2'b00);
    wr(2'd1, 21'd2, 12'd0, 15'h0200, 2'b00);
    wr(2'd2, 21'd1, 12'd0, 15'h0000, 2'b00);
    wr(2'd3, 21'd1, 12'd0, 15'h0000, 2'b00);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; sample_req = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0; cfg_half = '0; cfg_amp = '0; cfg_pan = '0;
    cyc(); cyc();
    Reset = 1'b0;
    chk("rst_l", 32'(LDATA), 32'h0);
    chk("rst_r", 32'(RDATA), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_seg", 32'(seg_idx), 32'h0);

    // One-shot playback
    load_base();
    pulse_start();
    chk("os_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) req("os", seq[i], seq[i], (i == 7), seq_seg[i]);
    chk("os_idle", 32'(busy), 32'h0);
    chk("os_done_clr", 32'(done), 32'h0);

    // Looping playback, then loop dropped
    loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) req("lp", seq[i % 8], seq[i % 8], 1'b0, seq_seg[i % 8]);
    chk("lp_busy", 32'(busy), 32'h1);
    loop = 1'b0;
    for (int i = 20; i < 24; i++) req("lp_end", seq[i % 8], seq[i % 8], (i == 23), seq_seg[i % 8]);
    chk("lp_idle", 32'(busy), 32'h0);

    // Stop mid-segment, coinciding with a strobe
    pulse_start();
    for (int i = 0; i < 3; i++) req("st", seq[i], seq[i], 1'b0, seq_seg[i]);
    stop = 1'b1; sample_req = 1'b1;
    cyc();
    stop = 1'b0; sample_req = 1'b0;
    chk("st_l", 32'(LDATA), 32'h0);
    chk("st_busy", 32'(busy), 32'h0);
    chk("st_done", 32'(done), 32'h0);
    chk("st_seg", 32'(seg_idx), 32'h0);
    pulse_start();
    req("st_re", 16'h1000, 16'h1000, 1'b0, 2'd0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // dur = 0 plays a single sample
    wr(2'd0, 21'd0, 12'd0, 15'h0123, 2'b00);
    wr(2'd1, 21'd1, 12'd0, 15'h0456, 2'b00);
    pulse_start();
    req("d0_a", 16'h0123, 16'h0123, 1'b0, 2'd1);
    req("d0_b", 16'h0456, 16'h0456, 1'b0, 2'd2);
    req("d0_c", 16'h0000, 16'h0000, 1'b0, 2'd3);
    req("d0_d", 16'h0000, 16'h0000, 1'b1, 2'd0);

    // start and sample_req together; table write while busy
    start = 1'b1; sample_req = 1'b1;
    cyc();
    start = 1'b0; sample_req = 1'b0;
    chk("co_l", 32'(LDATA), 32'h0);
    chk("co_busy", 32'(busy), 32'h1);
    wr(2'd0, 21'd5, 12'd0, 15'h7FFF, 2'b00);
    req("co_a", 16'h0123, 16'h0123, 1'b0, 2'd1);
    req("co_b", 16'h0456, 16'h0456, 1'b0, 2'd2);
    req("co_c", 16'h0000, 16'h0000, 1'b0, 2'd3);
    req("co_d", 16'h0000, 16'h0000, 1'b1, 2'd0);
    pulse_start();
    req("we_ro", 16'h0123, 16'h0123, 1'b0, 2'd1);

    // Reset during playback clears the table
    Reset = 1'b1; cyc(); Reset = 1'b0;
    chk("rp_l", 32'(LDATA), 32'h0);
    chk("rp_seg", 32'(seg_idx), 32'h0);
    chk("rp_busy", 32'(busy), 32'h0);
    pulse_start();
    req("rp_a", 16'h0000, 16'h0000, 1'b0, 2'd1);
    req("rp_b", 16'h0000, 16'h0000, 1'b0, 2'd2);
    req("rp_c", 16'h0000, 16'h0000, 1'b0, 2'd3);
    req("rp_d", 16'h0000, 16'h0000, 1'b1, 2'd0);

`ifdef TONE_SEQ_PAN_EN
    wr(2'd0, 21'd1, 12'd0, 15'h1000, 2'b01);
    wr(2'd1, 21'd2, 12'd1, 15'h1000, 2'b11);
    wr(2'd2, 21'd1, 12'd0, 15'h0000, 2'b00);
    wr(2'd3, 21'd1, 12'd0, 15'h0000, 2'b00);
    pulse_start();
    req("pan_l", 16'h1000, 16'h0000, 1'b0, 2'd1);
    req("pan_hp", 16'h0800, 16'h0800, 1'b0, 2'd1);
    req("pan_hn", 16'hF800, 16'hF800, 1'b0, 2'd2);
    stop = 1'b1; cyc(); stop = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
